// File: rtl/fetch_pc_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_gen_if
//  Description : Bundles the fetch-PC generator's control, instruction-memory
//                and F/D-register signals into one interface.
//                master : the fetch_pc_gen block itself
//                slave  : hazard unit / branch resolution / imem / F/D reg
//  Ports       : F_stall_i, redirect_i, redirect_pc_i      (control in)
//                imem_req_o, imem_addr_o                   (imem request)
//                imem_gnt_i, imem_rvalid_i, imem_rdata_i   (imem response)
//                instr_o, F_PC_o, F_nPC_o, F_commit_o      (to F/D register)
//                F_misalign_o  (only with FETCH_MISALIGN_CHK_EN defined)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_gen_if #(
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned INSTR_WIDTH = 32
);
   logic                   F_stall_i;
   logic                   redirect_i;
   logic [PC_WIDTH-1:0]    redirect_pc_i;
   logic                   imem_req_o;
   logic [PC_WIDTH-1:0]    imem_addr_o;
   logic                   imem_gnt_i;
   logic                   imem_rvalid_i;
   logic [INSTR_WIDTH-1:0] imem_rdata_i;
   logic [INSTR_WIDTH-1:0] instr_o;
   logic [PC_WIDTH-1:0]    F_PC_o;
   logic [PC_WIDTH-1:0]    F_nPC_o;
   logic                   F_commit_o;
`ifdef FETCH_MISALIGN_CHK_EN
   logic                   F_misalign_o;
`endif

   modport master (
      input  F_stall_i, redirect_i, redirect_pc_i,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      output imem_req_o, imem_addr_o,
      output instr_o, F_PC_o, F_nPC_o, F_commit_o
`ifdef FETCH_MISALIGN_CHK_EN
      , output F_misalign_o
`endif
   );

   modport slave (
      output F_stall_i, redirect_i, redirect_pc_i,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      input  imem_req_o, imem_addr_o,
      input  instr_o, F_PC_o, F_nPC_o, F_commit_o
`ifdef FETCH_MISALIGN_CHK_EN
      , input F_misalign_o
`endif
   );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_gen
//  Description : Front half of the fetch stage. Owns the architectural fetch
//                PC, keeps at most one instruction-memory request in flight
//                and presents the fetched instruction, its PC, PC+4 (static
//                not-taken prediction) and a commit flag to the F/D register.
//                Redirects have priority in every state; F-stall holds the
//                presented instruction.
//  Ports       : clk_i  - clock, rising edge
//                rst    - asynchronous active-high reset
//                bus    - fetch_pc_gen_if.master (control, imem, F/D outputs)
//  Options     : FETCH_MISALIGN_CHK_EN - when defined, a PC with nonzero
//                low bits is not requested; a NOP is presented instead with
//                F_misalign_o set.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen #(
   parameter int unsigned           PC_WIDTH    = 32,
   parameter int unsigned           INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]   RESET_PC    = 32'h0000_0000,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic              clk_i,
   input  logic              rst,
   fetch_pc_gen_if.master    bus
);

   localparam logic [PC_WIDTH-1:0] c_PC_INC  = PC_WIDTH'(4);
   localparam logic [PC_WIDTH-1:0] c_PC_ZERO = '0;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_VALID = 2'd2
   } state_t;

   state_t                 r_state,  w_state_nxt;
   logic [PC_WIDTH-1:0]    r_pc,     w_pc_nxt;
   logic                   r_drop,   w_drop_nxt;
   logic [INSTR_WIDTH-1:0] r_instr,  w_instr_nxt;
   logic [PC_WIDTH-1:0]    r_fpc,    w_fpc_nxt;
   logic [PC_WIDTH-1:0]    r_fnpc,   w_fnpc_nxt;
   logic                   r_commit, w_commit_nxt;
   logic [PC_WIDTH-1:0]    w_pc_plus4;
   logic                   w_req;
`ifdef FETCH_MISALIGN_CHK_EN
   logic                   r_misalign, w_misalign_nxt;
   logic                   w_pc_misaligned;

   assign w_pc_misaligned = |r_pc[1:0];
`endif

   // Wraps modulo 2^PC_WIDTH by construction.
   assign w_pc_plus4 = r_pc + c_PC_INC;

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         r_state    <= ST_REQ;
         r_pc       <= RESET_PC;
         r_drop     <= 1'b0;
         r_instr    <= NOP_INSTR;
         r_fpc      <= c_PC_ZERO;
         r_fnpc     <= c_PC_ZERO;
         r_commit   <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
         r_misalign <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_drop     <= w_drop_nxt;
         r_instr    <= w_instr_nxt;
         r_fpc      <= w_fpc_nxt;
         r_fnpc     <= w_fnpc_nxt;
         r_commit   <= w_commit_nxt;
`ifdef FETCH_MISALIGN_CHK_EN
         r_misalign <= w_misalign_nxt;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and request logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_drop_nxt     = r_drop;
      w_instr_nxt    = r_instr;
      w_fpc_nxt      = r_fpc;
      w_fnpc_nxt     = r_fnpc;
      w_commit_nxt   = r_commit;
`ifdef FETCH_MISALIGN_CHK_EN
      w_misalign_nxt = r_misalign;
`endif
      w_req          = 1'b0;

      unique case (r_state)
         ST_REQ: begin
            // rst gates the request so nothing is issued while reset is held,
            // independent of the (already reset) state register.
            w_req = ~bus.redirect_i & ~rst;
`ifdef FETCH_MISALIGN_CHK_EN
            w_req = w_req & ~w_pc_misaligned;
`endif
            if (bus.redirect_i) begin
               w_pc_nxt = bus.redirect_pc_i;
            end
`ifdef FETCH_MISALIGN_CHK_EN
            else if (w_pc_misaligned) begin
               // Present a flagged NOP instead of touching memory.
               w_instr_nxt    = NOP_INSTR;
               w_fpc_nxt      = r_pc;
               w_fnpc_nxt     = w_pc_plus4;
               w_commit_nxt   = 1'b1;
               w_misalign_nxt = 1'b1;
               w_state_nxt    = ST_VALID;
            end
`endif
            else if (bus.imem_gnt_i) begin
               w_state_nxt = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (bus.redirect_i) begin
               w_pc_nxt = bus.redirect_pc_i;
            end
            if (bus.imem_rvalid_i) begin
               if (r_drop || bus.redirect_i) begin
                  // Response belongs to a squashed fetch path.
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = ST_REQ;
               end else begin
                  w_instr_nxt  = bus.imem_rdata_i;
                  w_fpc_nxt    = r_pc;
                  w_fnpc_nxt   = w_pc_plus4;
                  w_commit_nxt = 1'b1;
                  w_state_nxt  = ST_VALID;
               end
            end else if (bus.redirect_i) begin
               // Request still in flight: remember to throw its data away.
               w_drop_nxt = 1'b1;
            end
         end

         ST_VALID: begin
            // A redirect flushes even while the F/D register is stalled.
            if (bus.redirect_i || !bus.F_stall_i) begin
               w_pc_nxt       = bus.redirect_i ? bus.redirect_pc_i : w_pc_plus4;
               w_instr_nxt    = NOP_INSTR;
               w_fpc_nxt      = c_PC_ZERO;
               w_fnpc_nxt     = c_PC_ZERO;
               w_commit_nxt   = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
               w_misalign_nxt = 1'b0;
`endif
               w_state_nxt    = ST_REQ;
            end
         end

         default: begin
            w_state_nxt = ST_REQ;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output drive
   // ------------------------------------------------------------------------
   assign bus.imem_req_o   = w_req;
   assign bus.imem_addr_o  = r_pc;
   assign bus.instr_o      = r_instr;
   assign bus.F_PC_o       = r_fpc;
   assign bus.F_nPC_o      = r_fnpc;
   assign bus.F_commit_o   = r_commit;
`ifdef FETCH_MISALIGN_CHK_EN
   assign bus.F_misalign_o = r_misalign;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_gen
//  Description : Directed self-checking bench for fetch_pc_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_gen;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   fetch_pc_gen_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

   fetch_pc_gen #(
      .PC_WIDTH   (32),
      .INSTR_WIDTH(32),
      .RESET_PC   (32'h0000_0000),
      .NOP_INSTR  (32'h0000_0013)
   ) dut (
      .clk_i (clk),
      .rst   (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.F_stall_i     = 1'b0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 32'h0;
      bus.imem_gnt_i    = 1'b0;
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'h0;
      #2;

      // ---- reset state ----
      chk("rst_req",    64'(bus.imem_req_o), 64'd0);
      chk("rst_instr",  64'(bus.instr_o),    64'h13);
      chk("rst_fpc",    64'(bus.F_PC_o),     64'h0);
      chk("rst_fnpc",   64'(bus.F_nPC_o),    64'h0);
      chk("rst_commit", 64'(bus.F_commit_o), 64'd0);

      // ---- basic fetch, immediate gnt/rvalid ----
      tick();
      rst = 1'b0;
      bus.imem_gnt_i    = 1'b1;
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = 32'h0050_0093;
      #1;
      chk("req0_valid", 64'(bus.imem_req_o),  64'd1);
      chk("req0_addr",  64'(bus.imem_addr_o), 64'h0);
      tick();   // -> WAIT
      chk("wait_noreq", 64'(bus.imem_req_o),  64'd0);
      chk("wait_commit",64'(bus.F_commit_o),  64'd0);
      bus.F_stall_i = 1'b1;      // hold the next VALID entry
      tick();   // -> VALID
      chk("v0_commit",  64'(bus.F_commit_o), 64'd1);
      chk("v0_instr",   64'(bus.instr_o),    64'h0050_0093);
      chk("v0_fpc",     64'(bus.F_PC_o),     64'h0);
      chk("v0_fnpc",    64'(bus.F_nPC_o),    64'h4);

      // ---- stall held 5 cycles in VALID ----
      bus.imem_rdata_i = 32'hDEAD_BEEF;  // must not leak in while stalled
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_commit", 64'(bus.F_commit_o), 64'd1);
         chk("stall_instr",  64'(bus.instr_o),    64'h0050_0093);
         chk("stall_fpc",    64'(bus.F_PC_o),     64'h0);
         chk("stall_req",    64'(bus.imem_req_o), 64'd0);
      end
      bus.F_stall_i = 1'b0;
      tick();   // consumed -> REQ, pc = 4
      chk("cons_commit", 64'(bus.F_commit_o),  64'd0);
      chk("cons_instr",  64'(bus.instr_o),     64'h13);
      chk("req1_valid",  64'(bus.imem_req_o),  64'd1);
      chk("req1_addr",   64'(bus.imem_addr_o), 64'h4);

      // ---- redirect in WAIT, rvalid two cycles later ----
      bus.imem_rvalid_i = 1'b0;
      tick();   // -> WAIT (addr 4 outstanding)
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h0000_0100;
      tick();   // drop set, pc = 0x100
      bus.redirect_i    = 1'b0;
      tick();   // still waiting
      chk("rdw_wait_req", 64'(bus.imem_req_o), 64'd0);
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = 32'h1111_1111;
      tick();   // response discarded -> REQ
      chk("rdw_commit",  64'(bus.F_commit_o),  64'd0);
      chk("rdw_instr",   64'(bus.instr_o),     64'h13);
      chk("rdw_req",     64'(bus.imem_req_o),  64'd1);
      chk("rdw_addr",    64'(bus.imem_addr_o), 64'h100);

      // ---- redirect and rvalid in the same WAIT cycle ----
      bus.imem_rvalid_i = 1'b0;
      tick();   // -> WAIT
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h0000_0200;
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = 32'h2222_2222;
      tick();   // discard -> REQ, pc = 0x200
      bus.redirect_i    = 1'b0;
      #1;
      chk("rdv_commit", 64'(bus.F_commit_o),  64'd0);
      chk("rdv_req",    64'(bus.imem_req_o),  64'd1);
      chk("rdv_addr",   64'(bus.imem_addr_o), 64'h200);

      // ---- redirect in VALID while stalled ----
      bus.imem_rdata_i = 32'h3333_3333;
      tick();   // -> WAIT
      tick();   // -> VALID
      chk("rv_commit0", 64'(bus.F_commit_o), 64'd1);
      chk("rv_fpc0",    64'(bus.F_PC_o),     64'h200);
      chk("rv_fnpc0",   64'(bus.F_nPC_o),    64'h204);
      bus.F_stall_i     = 1'b1;
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h0000_0300;
      tick();   // flushed -> REQ
      chk("rv_commit",  64'(bus.F_commit_o),  64'd0);
      chk("rv_instr",   64'(bus.instr_o),     64'h13);
      // Redirect still high in REQ: request suppressed, pc retargeted.
      bus.redirect_pc_i = 32'h0000_0400;
      #1;
      chk("rreq_supp",  64'(bus.imem_req_o),  64'd0);
      tick();
      bus.redirect_i = 1'b0;
      bus.F_stall_i  = 1'b0;
      #1;
      chk("rreq_req",   64'(bus.imem_req_o),  64'd1);
      chk("rreq_addr",  64'(bus.imem_addr_o), 64'h400);

      // ---- PC wrap at the top of the address space ----
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'hFFFF_FFFC;
      tick();   // stays REQ with pc = FFFF_FFFC
      bus.redirect_i    = 1'b0;
      bus.imem_rdata_i  = 32'h4444_4444;
      #1;
      chk("wrap_addr",  64'(bus.imem_addr_o), 64'hFFFF_FFFC);
      tick();   // -> WAIT
      tick();   // -> VALID
      chk("wrap_fpc",   64'(bus.F_PC_o),      64'hFFFF_FFFC);
      chk("wrap_fnpc",  64'(bus.F_nPC_o),     64'h0);
      chk("wrap_instr", 64'(bus.instr_o),     64'h4444_4444);
      tick();   // consumed -> REQ at 0
      chk("wrap_next",  64'(bus.imem_addr_o), 64'h0);

      // ---- async reset mid-WAIT ----
      bus.imem_rvalid_i = 1'b0;
      tick();   // -> WAIT (addr 0 outstanding)
      tick();   // -> VALID? no: rvalid low, still WAIT
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = 32'h5555_5555;
      tick();   // -> VALID (pc 0)
      chk("ar_pre_commit", 64'(bus.F_commit_o), 64'd1);
      tick();   // consumed -> REQ pc = 4
      bus.imem_rvalid_i = 1'b0;
      tick();   // -> WAIT with pc = 4
      chk("ar_pre_addr", 64'(bus.imem_addr_o), 64'h4);
      #2;
      rst = 1'b1;   // between edges
      #1;
      chk("ar_addr",   64'(bus.imem_addr_o), 64'h0);
      chk("ar_req",    64'(bus.imem_req_o),  64'd0);
      chk("ar_commit", 64'(bus.F_commit_o),  64'd0);
      chk("ar_instr",  64'(bus.instr_o),     64'h13);
      tick();
      rst = 1'b0;
      bus.imem_gnt_i    = 1'b0;
      bus.imem_rvalid_i = 1'b1;   // late response after reset
      bus.imem_rdata_i  = 32'h6666_6666;
      tick();
      chk("ar_late_commit", 64'(bus.F_commit_o),  64'd0);
      chk("ar_late_req",    64'(bus.imem_req_o),  64'd1);
      chk("ar_late_addr",   64'(bus.imem_addr_o), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Front half of the fetch stage. Owns the architectural fetch PC and issues one instruction-memory request at a time.
- Presents the fetched instruction, its PC, its predicted next PC (PC+4, static not-taken) and a valid/commit flag to the F/D pipeline register.
- Honours the F-stage stall from the hazard unit and accepts PC redirects from the branch/jump resolution logic.

Parameters:
- PC_WIDTH, 32, width of PC, nPC, redirect and memory address.
- INSTR_WIDTH, 32, width of instruction word.
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INSTR, 32'h0000_0013, instruction value driven when no valid instruction is held.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- F_stall_i  in  1  downstream F/D register holding; presented instruction must stay unchanged.
- redirect_i  in  1  branch/jump taken; restart fetch at redirect_pc_i.
- redirect_pc_i  in  PC_WIDTH  redirect target.
- imem_req_o  out  1  memory request valid.
- imem_addr_o  out  PC_WIDTH  request address, equals current PC.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  INSTR_WIDTH  response instruction.
- instr_o  out  INSTR_WIDTH  fetched instruction to F/D register.
- F_PC_o  out  PC_WIDTH  PC of instr_o.
- F_nPC_o  out  PC_WIDTH  F_PC_o + 4.
- F_commit_o  out  1  instr_o is a real instruction.

Behaviour:
- Reset (async, rst=1): pc_q=RESET_PC, state=REQ, drop_q=0, instr_o=NOP_INSTR, F_PC_o=0, F_nPC_o=0, F_commit_o=0. imem_req_o is 0 while rst is high.
- States:
  - REQ: imem_req_o = ~redirect_i, imem_addr_o = pc_q. On gnt and no redirect, go to WAIT.
  - WAIT: one request is outstanding and imem_req_o=0. On rvalid:
    - if drop_q or redirect_i: discard the data, clear drop_q, go to REQ.
    - else: capture instr_o=rdata, F_PC_o=pc_q, F_nPC_o=pc_q+4, F_commit_o=1, go to VALID.
  - VALID: outputs held. If ~F_stall_i, the instruction is consumed this edge: pc_q<=pc_q+4, outputs return to NOP values with F_commit_o=0, go to REQ. If F_stall_i, stay in VALID with all outputs unchanged, for any number of cycles.
- Redirect has highest priority in every state. pc_q<=redirect_pc_i on that edge.
  - REQ: the request is suppressed that cycle; stay in REQ.
  - WAIT: set drop_q and stay in WAIT. The in-flight response is discarded when it arrives; the next REQ uses the new PC.
  - VALID: outputs become NOP with commit 0, go to REQ. This applies even if F_stall_i is high, because redirect flushes.
- gnt is ignored outside REQ. rvalid is ignored outside WAIT.
- PC arithmetic is modulo 2^PC_WIDTH; 32'hFFFF_FFFC+4 wraps to 0.
- Latency: no stall, no redirect, gnt and rvalid both immediate gives one instruction every 3 cycles (REQ, WAIT, VALID). Only one request is ever outstanding.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output F_misalign_o (1 bit, reset 0).
  - If pc_q[1:0]!=0 while in REQ, no memory request is issued. The block goes directly to VALID with instr_o=NOP_INSTR, F_PC_o=pc_q, F_nPC_o=pc_q+4, F_commit_o=1, F_misalign_o=1.
  - F_misalign_o clears whenever the VALID entry is consumed or flushed.
- Undefined: no port, no check; misaligned PCs are requested like any other.

Test Plan:
- Reset release, gnt and rvalid immediate, rdata 32'h00500093: F_commit_o=1 with F_PC_o=0, F_nPC_o=4 two cycles after the first REQ; the next request has imem_addr_o=4.
- F_stall_i held 5 cycles in VALID: instr_o, F_PC_o and F_commit_o are constant. pc_q advances to +4 only on the edge after the stall drops.
- redirect_i to 32'h0000_0100 in WAIT, rvalid 2 cycles later: data discarded, F_commit_o stays 0, the next request address is 0x100.
- redirect_i and rvalid in the same WAIT cycle: data discarded, next request address is the redirect PC.
- redirect_i in VALID with F_stall_i=1: F_commit_o=0 next cycle, instr_o=32'h13, REQ to the redirect PC.
- Async rst asserted mid-WAIT: outputs return to reset values immediately without a clock edge. After release, a late rvalid is ignored and the first request is to RESET_PC.
